// File: rtl/instr_mem_sync_if.sv
// Fetch-side bus of the instruction memory: request and response valid/ready
// handshakes. The memory takes the slave modport; the fetch stage (or a bench)
// takes the master modport.
interface instr_mem_sync_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the RV32I fetch stage.
// After reset every word is filled with NOP_WORD, one word per cycle. Fetches
// then return data one cycle after acceptance and hold it while the consumer
// stalls. Misaligned and out-of-range fetches are flagged instead of aliased.
// A run-time loader port writes the program and takes priority over fetches.
module instr_mem_sync #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_sync_if.slave    fetch,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [31:0]        ld_data,
  output logic               init_done
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_fill_cnt;
  logic [31:0]      r_mem [DEPTH];

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_instr;
  logic [1:0]       r_rsp_fault;

  logic             w_fill_last;
  logic             w_req_ready;
  logic             w_accept;
  logic [31:0]      w_off;
  logic             w_misalign;
  logic             w_oor;
  logic [IDX_W-1:0] w_idx;

  assign w_fill_last = (r_fill_cnt == IDX_W'(DEPTH - 1));

  // Address decode. BASE_ADDR is DEPTH*4 aligned, so the low offset bits equal
  // the low address bits; addresses below BASE wrap large and land in w_oor.
  assign w_off      = fetch.req_addr - BASE_ADDR;
  assign w_misalign = |w_off[1:0];
  assign w_oor      = (w_off >> (IDX_W + 2)) != '0;
  assign w_idx      = w_off[IDX_W+1:2];

  assign w_accept = fetch.req_valid && w_req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; loader writes block fetch acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    init_done   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_fill_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done   = 1'b1;
        w_req_ready = !ld_en && (!r_rsp_valid || fetch.rsp_ready);
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Fill counter: walks words 0..DEPTH-1 once per reset and stops at the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_INIT && !w_fill_last) begin
      r_fill_cnt <= r_fill_cnt + IDX_W'(1);
    end
  end

  // Memory write port: NOP fill during INIT, loader writes in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_fill_cnt] <= NOP_WORD;
      end else if (ld_en) begin
        r_mem[ld_idx] <= ld_data;
      end
    end
  end

  // Response register: loads only on accept, so a stalled response (and any
  // loader write during the stall) leaves rsp_instr/rsp_fault untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= NOP_WORD;
      r_rsp_fault <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_fault <= {w_oor, w_misalign};
      r_rsp_instr <= (w_oor || w_misalign) ? NOP_WORD : r_mem[w_idx];
    end else if (fetch.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign fetch.req_ready = w_req_ready;
  assign fetch.rsp_valid = r_rsp_valid;
  assign fetch.rsp_instr = r_rsp_instr;
  assign fetch.rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: a behavioural model compared every cycle, plus
// directed fetch/load sequences with literal expectations.
module tb_instr_mem_sync;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_sync_if bus ();
  instr_mem_sync_if bus2 ();

  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_data;
  logic        init_done;
  logic        ld_en2;
  logic [7:0]  ld_idx2;
  logic [31:0] ld_data2;
  logic        init_done2;

  int errors = 0;
  int checks = 0;

  instr_mem_sync #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(bus.slave),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .init_done(init_done)
  );

  instr_mem_sync #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_1000), .NOP_WORD(NOP)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch(bus2.slave),
    .ld_en(ld_en2), .ld_idx(ld_idx2), .ld_data(ld_data2), .init_done(init_done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of dut: memory reads as all-NOP once DEPTH init cycles have passed.
  logic        m_known = 1'b0;
  int          m_init_left;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;
  logic [31:0] m_mem [DEPTH];

  always @(posedge clk) begin
    logic        rdy;
    logic [31:0] off;
    if (!rst_n) begin
      m_known     = 1'b1;
      m_init_left = DEPTH;
      m_valid     = 1'b0;
      m_instr     = NOP;
      m_fault     = 2'b00;
    end else if (m_known && m_init_left > 0) begin
      m_init_left = m_init_left - 1;
      if (m_init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
      end
    end else if (m_known) begin
      rdy = !ld_en && (!m_valid || bus.rsp_ready);
      if (ld_en) m_mem[ld_idx] = ld_data;
      if (bus.req_valid && rdy) begin
        off        = bus.req_addr;
        m_valid    = 1'b1;
        m_fault[0] = (bus.req_addr % 4) != 0;
        m_fault[1] = longint'(off) >= longint'(DEPTH * 4);
        m_instr    = (m_fault != 2'b00) ? NOP : m_mem[off / 4];
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_init_done", init_done, m_init_left == 0);
      chk("m_req_ready", bus.req_ready,
          (m_init_left == 0) && !ld_en && (!m_valid || bus.rsp_ready));
      chk("m_rsp_valid", bus.rsp_valid, m_valid);
      if (m_valid) begin
        chk("m_rsp_instr", bus.rsp_instr, m_instr);
        chk("m_rsp_fault", bus.rsp_fault, m_fault);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 300) begin
      chk("init_rdy", bus.req_ready, 0);
      step();
      n++;
    end
    chk("init_len", n, 256);
    chk("init2_done", init_done2, 1);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                       input logic [1:0] ef, input string nm);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b1;
    #1;
    chk({nm, "_rdy"}, bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    chk({nm, "_vld"}, bus.rsp_valid, 1);
    chk({nm, "_ins"}, bus.rsp_instr, ei);
    chk({nm, "_flt"}, bus.rsp_fault, ef);
  endtask

  task automatic fetch2(input logic [31:0] a, input logic [31:0] ei,
                        input logic [1:0] ef, input string nm);
    bus2.req_valid = 1'b1;
    bus2.req_addr  = a;
    bus2.rsp_ready = 1'b1;
    #1;
    chk({nm, "_rdy"}, bus2.req_ready, 1);
    step();
    bus2.req_valid = 1'b0;
    chk({nm, "_vld"}, bus2.rsp_valid, 1);
    chk({nm, "_ins"}, bus2.rsp_instr, ei);
    chk({nm, "_flt"}, bus2.rsp_fault, ef);
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = idx; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    ld_en2 = 1'b0; ld_idx2 = '0; ld_data2 = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.rsp_ready = 1'b1;

    // 1: reset values, INIT length, first fetch
    step(); step();
    chk("rst_vld", bus.rsp_valid, 0);
    chk("rst_ins", bus.rsp_instr, NOP);
    chk("rst_flt", bus.rsp_fault, 0);
    chk("rst_done", init_done, 0);
    rst_n = 1'b1;
    wait_init();
    fetch(32'h3FC, NOP, 2'b00, "f3fc");
    step();

    // 2: load two words, back-to-back fetch
    load(8'd0, 32'h0050_0093);
    load(8'd1, 32'h00a0_0113);
    bus.req_valid = 1'b1; bus.req_addr = 32'h0;
    step();
    chk("b2b0", bus.rsp_instr, 32'h0050_0093);
    bus.req_addr = 32'h4;
    step();
    chk("b2b1", bus.rsp_instr, 32'h00a0_0113);
    chk("b2b1_vld", bus.rsp_valid, 1);
    bus.req_valid = 1'b0;
    step();
    chk("b2b_drop", bus.rsp_valid, 0);

    // 3: faults
    fetch(32'h2, NOP, 2'b01, "mis");
    fetch(32'h400, NOP, 2'b10, "oor");
    fetch(32'hFFFF_FFFE, NOP, 2'b11, "both");
    fetch2(32'h0FFC, NOP, 2'b10, "below");
    fetch2(32'h1004, NOP, 2'b00, "b1004");
    fetch2(32'h1400, NOP, 2'b10, "b1400");
    step();

    // 4: stall holds response; loader write during stall does not disturb it
    bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b0;
    #1;
    chk("st_rdy0", bus.req_ready, 1);
    step();
    bus.req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("st_rdy", bus.req_ready, 0);
      chk("st_vld", bus.rsp_valid, 1);
      chk("st_ins", bus.rsp_instr, 32'h00a0_0113);
      if (i == 1) begin
        ld_en = 1'b1; ld_idx = 8'd1; ld_data = 32'h00c0_0193;
      end
      step();
      ld_en = 1'b0;
    end
    chk("st_hold", bus.rsp_instr, 32'h00a0_0113);
    bus.rsp_ready = 1'b1;
    #1;
    chk("st_rel_rdy", bus.req_ready, 1);
    step();
    chk("st_rel_ins", bus.rsp_instr, 32'h0050_0093);
    fetch(32'h4, 32'h00c0_0193, 2'b00, "st_new");

    // 5: loader priority, then read-after-write
    bus.req_valid = 1'b1; bus.req_addr = 32'h8;
    ld_en = 1'b1; ld_idx = 8'd2; ld_data = 32'h1234_5678;
    #1;
    chk("ldp_rdy", bus.req_ready, 0);
    step();
    ld_en = 1'b0;
    #1;
    chk("raw_rdy", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    chk("raw_ins", bus.rsp_instr, 32'h1234_5678);
    chk("raw_flt", bus.rsp_fault, 0);
    step();

    // 6: reset with a pending response, then reset mid-fill
    bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    chk("pend_vld", bus.rsp_valid, 1);
    rst_n = 1'b0;
    step();
    chk("pend_rst_vld", bus.rsp_valid, 0);
    chk("pend_rst_ins", bus.rsp_instr, NOP);
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        ld_en = 1'b1; ld_idx = 8'd3; ld_data = 32'hAAAA_5555;
      end
      step();
      ld_en = 1'b0;
    end
    rst_n = 1'b0;
    step();
    chk("mid_done", init_done, 0);
    chk("mid_vld", bus.rsp_valid, 0);
    rst_n = 1'b1;
    wait_init();
    fetch(32'h0, NOP, 2'b00, "re0");
    fetch(32'h4, NOP, 2'b00, "re4");
    fetch(32'h8, NOP, 2'b00, "re8");
    fetch(32'hC, NOP, 2'b00, "reC");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
